// File: rtl/watch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | watch_pkg : field widths and moduli shared by the watch datapath      |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package watch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int MSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

endpackage
`default_nettype wire

// File: rtl/time_field_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_field_counter : modulo-MOD time field with run carry and         |
// |                      +-1/+-10 adjust steps                            |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module time_field_counter #(
  parameter int WIDTH = 6,
  parameter int MOD   = 60,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carry_in,
  input  logic             inc1,
  input  logic             inc10,
  input  logic             dec1,
  input  logic             dec10,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] c_init = WIDTH'(INIT);
  localparam logic [WIDTH:0]   c_mod  = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH:0]   c_ten  = (WIDTH + 1)'(10);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_up1;
  logic [WIDTH-1:0] w_up10;
  logic [WIDTH-1:0] w_dn1;
  logic [WIDTH-1:0] w_dn10;
  logic [WIDTH-1:0] w_next;

  // One extra bit of headroom so value+10 never overflows before the wrap test.
  assign w_ext  = {1'b0, r_value};
  assign w_up1  = (r_value == c_max) ? '0 : r_value + WIDTH'(1);
  assign w_dn1  = (r_value == '0) ? c_max : r_value - WIDTH'(1);
  assign w_up10 = WIDTH'(((w_ext + c_ten) >= c_mod) ? (w_ext + c_ten - c_mod)
                                                     : (w_ext + c_ten));
  assign w_dn10 = WIDTH'((w_ext >= c_ten) ? (w_ext - c_ten)
                                          : (w_ext + c_mod - c_ten));

  always_comb begin
    w_next = r_value;
    if (clr) begin
      w_next = c_init;
    end else if (carry_in) begin
      w_next = w_up1;
    end else if (inc1) begin
      w_next = w_up1;
    end else if (inc10) begin
      w_next = w_up10;
    end else if (dec1) begin
      w_next = w_dn1;
    end else if (dec10) begin
      w_next = w_dn10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= c_init;
    end else begin
      r_value <= w_next;
    end
  end

  assign value     = r_value;
  assign carry_out = carry_in & (r_value == c_max);

endmodule
`default_nettype wire

// File: rtl/watch_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | watch_datapath : prescaled hh:mm:ss.cc time keeper with field adjust  |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module watch_datapath
  import watch_pkg::*;
#(
  parameter int TICK_DIV  = 1_000_000,
  parameter int INIT_HOUR = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_stop,
  input  logic              inc_sec_1,
  input  logic              inc_sec_10,
  input  logic              dec_sec_1,
  input  logic              dec_sec_10,
  input  logic              inc_min_1,
  input  logic              inc_min_10,
  input  logic              dec_min_1,
  input  logic              dec_min_10,
  input  logic              inc_hour_1,
  input  logic              inc_hour_10,
  input  logic              dec_hour_1,
  input  logic              dec_hour_10,
  output logic [MSEC_W-1:0] msec,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              tick
);

  localparam int                  c_presc_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
  localparam logic [MSEC_W-1:0]    c_msec_max   = MSEC_W'(MSEC_MOD - 1);

  logic [c_presc_w-1:0] r_presc;
  logic [MSEC_W-1:0]    r_msec;
  logic                 r_tick;

  logic                 w_tc;
  logic                 w_adj_en;
  logic [3:0]           w_sec_adj;
  logic [3:0]           w_min_adj;
  logic [3:0]           w_hour_adj;
  logic                 w_any_adj;
  logic                 w_sec_carry_in;
  logic                 w_min_carry_in;
  logic                 w_hour_carry_in;
  logic                 w_unused_day_carry;

  // Adjust pulses only count while frozen; {inc1, inc10, dec1, dec10} per field.
  assign w_adj_en   = ~run_stop;
  assign w_sec_adj  = {inc_sec_1,  inc_sec_10,  dec_sec_1,  dec_sec_10}  & {4{w_adj_en}};
  assign w_min_adj  = {inc_min_1,  inc_min_10,  dec_min_1,  dec_min_10}  & {4{w_adj_en}};
  assign w_hour_adj = {inc_hour_1, inc_hour_10, dec_hour_1, dec_hour_10} & {4{w_adj_en}};
  assign w_any_adj  = |{w_sec_adj, w_min_adj, w_hour_adj};

  assign w_tc           = run_stop & (r_presc == c_presc_last);
  assign w_sec_carry_in = w_tc & (r_msec == c_msec_max);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (!run_stop || w_tc) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_presc_w'(1);
    end
  end

  // Any edit restarts the edited time on a whole second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msec <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tc;
      if (w_any_adj) begin
        r_msec <= '0;
      end else if (w_tc) begin
        r_msec <= (r_msec == c_msec_max) ? '0 : r_msec + MSEC_W'(1);
      end
    end
  end

  time_field_counter #(
    .WIDTH (SEC_W),
    .MOD   (SEC_MOD),
    .INIT  (0)
  ) u_sec (
    .clk       (clk),
    .rst       (rst),
    .carry_in  (w_sec_carry_in),
    .inc1      (w_sec_adj[3]),
    .inc10     (w_sec_adj[2]),
    .dec1      (w_sec_adj[1]),
    .dec10     (w_sec_adj[0]),
    .clr       (1'b0),
    .value     (sec),
    .carry_out (w_min_carry_in)
  );

  time_field_counter #(
    .WIDTH (MIN_W),
    .MOD   (MIN_MOD),
    .INIT  (0)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .carry_in  (w_min_carry_in),
    .inc1      (w_min_adj[3]),
    .inc10     (w_min_adj[2]),
    .dec1      (w_min_adj[1]),
    .dec10     (w_min_adj[0]),
    .clr       (1'b0),
    .value     (min),
    .carry_out (w_hour_carry_in)
  );

  time_field_counter #(
    .WIDTH (HOUR_W),
    .MOD   (HOUR_MOD),
    .INIT  (INIT_HOUR)
  ) u_hour (
    .clk       (clk),
    .rst       (rst),
    .carry_in  (w_hour_carry_in),
    .inc1      (w_hour_adj[3]),
    .inc10     (w_hour_adj[2]),
    .dec1      (w_hour_adj[1]),
    .dec10     (w_hour_adj[0]),
    .clr       (1'b0),
    .value     (hour),
    .carry_out (w_unused_day_carry)
  );

  assign msec = r_msec;
  assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_watch_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_watch_datapath : directed self-checking bench for watch_datapath   |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_watch_datapath;

  localparam int TICK_DIV  = 4;
  localparam int INIT_HOUR = 12;

  // Adjust vector bit positions
  localparam int A_IS1 = 0, A_IS10 = 1, A_DS1 = 2, A_DS10 = 3;
  localparam int A_IM1 = 4, A_IM10 = 5, A_DM1 = 6, A_DM10 = 7;
  localparam int A_IH1 = 8, A_IH10 = 9, A_DH1 = 10, A_DH10 = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_stop = 1'b0;
  logic [11:0] adj = '0;
  logic [6:0]  msec;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic        tick;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  watch_datapath #(
    .TICK_DIV  (TICK_DIV),
    .INIT_HOUR (INIT_HOUR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_stop    (run_stop),
    .inc_sec_1   (adj[A_IS1]),
    .inc_sec_10  (adj[A_IS10]),
    .dec_sec_1   (adj[A_DS1]),
    .dec_sec_10  (adj[A_DS10]),
    .inc_min_1   (adj[A_IM1]),
    .inc_min_10  (adj[A_IM10]),
    .dec_min_1   (adj[A_DM1]),
    .dec_min_10  (adj[A_DM10]),
    .inc_hour_1  (adj[A_IH1]),
    .inc_hour_10 (adj[A_IH10]),
    .dec_hour_1  (adj[A_DH1]),
    .dec_hour_10 (adj[A_DH10]),
    .msec        (msec),
    .sec         (sec),
    .min         (min),
    .hour        (hour),
    .tick        (tick)
  );

  function automatic logic [23:0] tm(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  function automatic logic [11:0] bit1(input int b);
    logic [11:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Drive an adjust pattern for k cycles; returns on the negedge after the last edge.
  task automatic hold_adj(input logic [11:0] v, input int k);
    @(negedge clk);
    adj = v;
    repeat (k) @(negedge clk);
    adj = '0;
  endtask

  task automatic run_ticks(input int n);
    @(negedge clk);
    run_stop = 1'b1;
    repeat (n * TICK_DIV) @(negedge clk);
    run_stop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    run_stop = 1'b0;
    adj = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(12, 0, 0, 0) || tick !== 1'b0)
      $display("FAIL reset_asserted: got %h tick %b, want %h tick 0", {hour, min, sec, msec}, tick, tm(12, 0, 0, 0));
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hour, min, sec, msec} !== tm(12, 0, 0, 0) || tick !== 1'b0)
        $display("FAIL reset_hold cyc %0d: got %h tick %b, want %h tick 0", i, {hour, min, sec, msec}, tick, tm(12, 0, 0, 0));
      else n_pass++;
    end
  endtask

  task automatic test_rollover;
    hold_adj(bit1(A_IH10), 1);
    hold_adj(bit1(A_IH1), 1);
    hold_adj(bit1(A_DM1), 1);
    hold_adj(bit1(A_DS1), 2);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(23, 59, 58, 0))
      $display("FAIL setup_adjust: got %h, want %h", {hour, min, sec, msec}, tm(23, 59, 58, 0));
    else n_pass++;
    run_ticks(198);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(23, 59, 59, 98))
      $display("FAIL run_198_ticks: got %h, want %h", {hour, min, sec, msec}, tm(23, 59, 59, 98));
    else n_pass++;
    @(negedge clk);
    run_stop = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (tick !== ((k == 4) || (k == 8)))
        $display("FAIL tick_timing edge %0d: got %b, want %b", k, tick, (k == 4) || (k == 8));
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if ({hour, min, sec, msec} !== tm(23, 59, 59, 99))
          $display("FAIL tick1_value: got %h, want %h", {hour, min, sec, msec}, tm(23, 59, 59, 99));
        else n_pass++;
      end
    end
    run_stop = 1'b0;
    n_checks++;
    if ({hour, min, sec, msec} !== tm(0, 0, 0, 0))
      $display("FAIL full_wrap: got %h, want %h", {hour, min, sec, msec}, tm(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_adjust;
    run_ticks(3);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(0, 0, 0, 3))
      $display("FAIL pre_adjust: got %h, want %h", {hour, min, sec, msec}, tm(0, 0, 0, 3));
    else n_pass++;
    hold_adj(bit1(A_DS1), 1);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(0, 0, 59, 0))
      $display("FAIL dec_sec_wrap_msec_clr: got %h, want %h", {hour, min, sec, msec}, tm(0, 0, 59, 0));
    else n_pass++;
    hold_adj(bit1(A_DS1), 4);
    n_checks++;
    if (sec !== 6'd55)
      $display("FAIL dec_sec_held: got %0d, want 55", sec);
    else n_pass++;
    hold_adj(bit1(A_IS10), 1);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(0, 0, 5, 0))
      $display("FAIL inc_sec_10_wrap: got %h, want %h", {hour, min, sec, msec}, tm(0, 0, 5, 0));
    else n_pass++;
    hold_adj(bit1(A_IH1), 5);
    hold_adj(bit1(A_DH10), 1);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(19, 0, 5, 0))
      $display("FAIL dec_hour_10_wrap: got %h, want %h", {hour, min, sec, msec}, tm(19, 0, 5, 0));
    else n_pass++;
    hold_adj(bit1(A_DM1), 1);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(19, 59, 5, 0))
      $display("FAIL dec_min_1_wrap: got %h, want %h", {hour, min, sec, msec}, tm(19, 59, 5, 0));
    else n_pass++;
    hold_adj(bit1(A_DH1), 1);
    hold_adj(bit1(A_IH10), 1);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(4, 59, 5, 0))
      $display("FAIL inc_hour_10_wrap: got %h, want %h", {hour, min, sec, msec}, tm(4, 59, 5, 0));
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    hold_adj(bit1(A_IS1), 5);
    hold_adj(bit1(A_IS1) | bit1(A_DS1), 1);
    n_checks++;
    if (sec !== 6'd11)
      $display("FAIL sec_inc1_over_dec1: got %0d, want 11", sec);
    else n_pass++;
    hold_adj(bit1(A_IS10) | bit1(A_DS1) | bit1(A_DS10), 1);
    n_checks++;
    if (sec !== 6'd21)
      $display("FAIL sec_inc10_priority: got %0d, want 21", sec);
    else n_pass++;
    hold_adj(bit1(A_DS1) | bit1(A_DS10), 1);
    n_checks++;
    if (sec !== 6'd20)
      $display("FAIL sec_dec1_over_dec10: got %0d, want 20", sec);
    else n_pass++;
    hold_adj(bit1(A_IM1) | bit1(A_IH1), 1);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(5, 0, 20, 0))
      $display("FAIL min_hour_together: got %h, want %h", {hour, min, sec, msec}, tm(5, 0, 20, 0));
    else n_pass++;
  endtask

  task automatic test_adjust_while_running;
    @(negedge clk);
    run_stop = 1'b1;
    repeat (2) @(negedge clk);
    adj = bit1(A_IH1) | bit1(A_DS1);
    @(negedge clk);
    adj = '0;
    repeat (13) @(negedge clk);
    run_stop = 1'b0;
    n_checks++;
    if ({hour, min, sec, msec} !== tm(5, 0, 20, 4))
      $display("FAIL adjust_ignored_running: got %h, want %h", {hour, min, sec, msec}, tm(5, 0, 20, 4));
    else n_pass++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hold_adj(bit1(A_DH1), 5);
    hold_adj(bit1(A_IM10), 3);
    hold_adj(bit1(A_IM1), 3);
    hold_adj(bit1(A_IS10), 2);
    hold_adj(bit1(A_IS1), 1);
    run_ticks(40);
    n_checks++;
    if ({hour, min, sec, msec} !== tm(7, 33, 21, 40))
      $display("FAIL pre_reset_time: got %h, want %h", {hour, min, sec, msec}, tm(7, 33, 21, 40));
    else n_pass++;
    run_stop = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({hour, min, sec, msec} !== tm(12, 0, 0, 0) || tick !== 1'b0)
      $display("FAIL async_reset_immediate: got %h tick %b, want %h tick 0", {hour, min, sec, msec}, tick, tm(12, 0, 0, 0));
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (tick !== (k == 4))
        $display("FAIL restart_tick edge %0d: got %b, want %b", k, tick, k == 4);
      else n_pass++;
    end
    run_stop = 1'b0;
    n_checks++;
    if ({hour, min, sec, msec} !== tm(12, 0, 0, 1))
      $display("FAIL restart_value: got %h, want %h", {hour, min, sec, msec}, tm(12, 0, 0, 1));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_adjust();
    test_simultaneous();
    test_adjust_while_running();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
